rob_gen2: RTL and testbench

- Parametrised second-generation reorder buffer for the out-of-order core. It sits between the decoder (allocation), the RS and LSB (two writeback ports), and the register file, predictor and LSB on the commit side.
- Commits at most one entry per cycle, in order.
- Adds over the previous ROB: parametrised depth and widths, an occupancy count, an operand-query port with writeback bypass, and a store-commit handshake with the LSB.
- Branch mispredicts trigger a single-cycle flush.

---
 rtl/rob_gen2.sv | 227 ++++++++++++++++++++++
 tb/tb_rob_gen2.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_gen2.sv
// rob_gen2: parametrised reorder buffer with in-order single commit,
// dual writeback, operand query with writeback bypass, LSB store
// handshake and single-cycle mispredict flush.
module rob_gen2 #(
  parameter int ROB_DEPTH = 16,
  parameter int IDX_W     = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int REG_W     = 5
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              alloc_en,
  input  logic [1:0]        alloc_op,
  input  logic              alloc_ready,
  input  logic [REG_W-1:0]  alloc_dest,
  input  logic [DATA_W-1:0] alloc_val,
  input  logic              alloc_pred_jump,
  input  logic [ADDR_W-1:0] alloc_pc,
  input  logic [ADDR_W-1:0] alloc_alt_pc,
  output logic [IDX_W-1:0]  alloc_idx,
  output logic              rob_full,
  output logic              rob_empty,
  output logic [IDX_W:0]    rob_count,
  input  logic              wb0_en,
  input  logic [IDX_W-1:0]  wb0_idx,
  input  logic [DATA_W-1:0] wb0_val,
  input  logic              wb1_en,
  input  logic [IDX_W-1:0]  wb1_idx,
  input  logic [DATA_W-1:0] wb1_val,
  input  logic [IDX_W-1:0]  query_idx,
  output logic              query_ready,
  output logic [DATA_W-1:0] query_val,
  output logic              rf_commit_en,
  output logic [IDX_W-1:0]  rf_commit_idx,
  output logic [REG_W-1:0]  rf_commit_dest,
  output logic [DATA_W-1:0] rf_commit_val,
  output logic              st_commit_req,
  output logic [IDX_W-1:0]  st_commit_idx,
  input  logic              st_commit_ack,
  output logic              bp_update_en,
  output logic [ADDR_W-1:0] bp_update_pc,
  output logic              bp_taken,
  output logic              roll_back,
  output logic [ADDR_W-1:0] corr_pc
);

  localparam logic [1:0] OP_REG   = 2'd0;
  localparam logic [1:0] OP_BR    = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;
  localparam logic [1:0] OP_LOAD  = 2'd3;

  localparam logic [IDX_W:0]   FULL_COUNT = (IDX_W + 1)'(ROB_DEPTH);
  localparam logic [IDX_W-1:0] IDX_ONE    = {{(IDX_W - 1){1'b0}}, 1'b1};

  // Per-entry control bits (reset) and payload (never reset, gated by busy/ready)
  logic [ROB_DEPTH-1:0] r_busy;
  logic [ROB_DEPTH-1:0] r_ready;
  logic [ROB_DEPTH-1:0] r_predJump;
  logic [1:0]           r_op    [ROB_DEPTH];
  logic [REG_W-1:0]     r_dest  [ROB_DEPTH];
  logic [DATA_W-1:0]    r_val   [ROB_DEPTH];
  logic [ADDR_W-1:0]    r_pc    [ROB_DEPTH];
  logic [ADDR_W-1:0]    r_altPc [ROB_DEPTH];

  logic [IDX_W-1:0] r_front;
  logic [IDX_W-1:0] r_rear;
  logic [IDX_W:0]   r_count;

  // Registered commit-side outputs
  logic              r_rfCommitEn;
  logic [IDX_W-1:0]  r_rfCommitIdx;
  logic [REG_W-1:0]  r_rfCommitDest;
  logic [DATA_W-1:0] r_rfCommitVal;
  logic              r_bpUpdateEn;
  logic [ADDR_W-1:0] r_bpUpdatePc;
  logic              r_bpTaken;
  logic              r_rollBack;
  logic [ADDR_W-1:0] r_corrPc;

  logic              w_full;
  logic [1:0]        w_headOp;
  logic [DATA_W-1:0] w_headVal;
  logic              w_headReady;
  logic              w_regCommit;
  logic              w_brCommit;
  logic              w_stReq;
  logic              w_mispredict;
  logic              w_pop;
  logic              w_allocFire;
  logic              w_wb0Hit;
  logic              w_wb1Hit;
  logic              w_qHit0;
  logic              w_qHit1;

  // Head-of-buffer commit decisions; nothing commits during the flush cycle
  always_comb begin
    w_full       = (r_count == FULL_COUNT);
    w_headOp     = r_op[r_front];
    w_headVal    = r_val[r_front];
    w_headReady  = (r_count != '0) && r_busy[r_front] && r_ready[r_front] && !r_rollBack;
    w_regCommit  = w_headReady && ((w_headOp == OP_REG) || (w_headOp == OP_LOAD));
    w_brCommit   = w_headReady && (w_headOp == OP_BR);
    w_stReq      = w_headReady && (w_headOp == OP_STORE);
    w_mispredict = w_brCommit && (w_headVal[0] != r_predJump[r_front]);
    w_pop        = w_regCommit || w_brCommit || (w_stReq && st_commit_ack);
    w_allocFire  = alloc_en && !w_full && !r_rollBack;
    w_wb0Hit     = wb0_en && r_busy[wb0_idx] && !r_rollBack;
    w_wb1Hit     = wb1_en && r_busy[wb1_idx] && !r_rollBack;
  end

  // Operand lookup: same-cycle writebacks bypass the stored value, wb1 first
  always_comb begin
    w_qHit0     = wb0_en && (wb0_idx == query_idx);
    w_qHit1     = wb1_en && (wb1_idx == query_idx);
    query_ready = r_ready[query_idx] || w_qHit0 || w_qHit1;
    if (w_qHit1) begin
      query_val = wb1_val;
    end else if (w_qHit0) begin
      query_val = wb0_val;
    end else if (r_ready[query_idx]) begin
      query_val = r_val[query_idx];
    end else begin
      query_val = '0;
    end
  end

  // Pointers, occupancy, busy/ready bits and commit pulses; a mispredict empties the buffer
  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_front        <= '0;
      r_rear         <= '0;
      r_count        <= '0;
      r_busy         <= '0;
      r_ready        <= '0;
      r_rfCommitEn   <= 1'b0;
      r_rfCommitIdx  <= '0;
      r_rfCommitDest <= '0;
      r_rfCommitVal  <= '0;
      r_bpUpdateEn   <= 1'b0;
      r_bpUpdatePc   <= '0;
      r_bpTaken      <= 1'b0;
      r_rollBack     <= 1'b0;
      r_corrPc       <= '0;
    end else if (rdy_in) begin
      r_rfCommitEn <= 1'b0;
      r_bpUpdateEn <= 1'b0;
      r_rollBack   <= 1'b0;
      if (w_regCommit) begin
        r_rfCommitEn   <= 1'b1;
        r_rfCommitIdx  <= r_front;
        r_rfCommitDest <= r_dest[r_front];
        r_rfCommitVal  <= w_headVal;
      end
      if (w_brCommit) begin
        r_bpUpdateEn <= 1'b1;
        r_bpUpdatePc <= r_pc[r_front];
        r_bpTaken    <= w_headVal[0];
      end
      if (w_mispredict) begin
        r_rollBack <= 1'b1;
        r_corrPc   <= r_altPc[r_front];
        r_front    <= '0;
        r_rear     <= '0;
        r_count    <= '0;
        r_busy     <= '0;
        r_ready    <= '0;
      end else begin
        if (w_wb0Hit) begin
          r_ready[wb0_idx] <= 1'b1;
        end
        if (w_wb1Hit) begin
          r_ready[wb1_idx] <= 1'b1;
        end
        if (w_pop) begin
          r_busy[r_front]  <= 1'b0;
          r_ready[r_front] <= 1'b0;
          r_front          <= r_front + IDX_ONE;
        end
        if (w_allocFire) begin
          r_busy[r_rear]  <= 1'b1;
          r_ready[r_rear] <= alloc_ready;
          r_rear          <= r_rear + IDX_ONE;
        end
        r_count <= r_count + {{IDX_W{1'b0}}, w_allocFire} - {{IDX_W{1'b0}}, w_pop};
      end
    end
  end

  // Entry payload: writeback values (wb1 after wb0 so it wins), then allocation overrides
  always_ff @(posedge clk) begin
    if (!rst_in && rdy_in) begin
      if (w_wb0Hit) begin
        r_val[wb0_idx] <= wb0_val;
      end
      if (w_wb1Hit) begin
        r_val[wb1_idx] <= wb1_val;
      end
      if (w_allocFire) begin
        r_op[r_rear]       <= alloc_op;
        r_dest[r_rear]     <= alloc_dest;
        r_val[r_rear]      <= alloc_val;
        r_predJump[r_rear] <= alloc_pred_jump;
        r_pc[r_rear]       <= alloc_pc;
        r_altPc[r_rear]    <= alloc_alt_pc;
      end
    end
  end

  assign alloc_idx      = r_rear;
  assign rob_full       = w_full;
  assign rob_empty      = (r_count == '0);
  assign rob_count      = r_count;
  assign st_commit_req  = w_stReq;
  assign st_commit_idx  = r_front;
  assign rf_commit_en   = r_rfCommitEn;
  assign rf_commit_idx  = r_rfCommitIdx;
  assign rf_commit_dest = r_rfCommitDest;
  assign rf_commit_val  = r_rfCommitVal;
  assign bp_update_en   = r_bpUpdateEn;
  assign bp_update_pc   = r_bpUpdatePc;
  assign bp_taken       = r_bpTaken;
  assign roll_back      = r_rollBack;
  assign corr_pc        = r_corrPc;

endmodule

// File: tb/tb_rob_gen2.sv
// tb_rob_gen2: directed vector table plus hand sequences for rob_gen2 at depth 4.
module tb_rob_gen2;

  localparam int DEPTH = 4;
  localparam int IW    = 2;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int RW    = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstIn, rdyIn;
  logic          allocEn, allocReady, allocPredJump;
  logic [1:0]    allocOp;
  logic [RW-1:0] allocDest;
  logic [DW-1:0] allocVal;
  logic [AW-1:0] allocPc, allocAltPc;
  logic [IW-1:0] allocIdx;
  logic          robFull, robEmpty;
  logic [IW:0]   robCount;
  logic          wb0En, wb1En;
  logic [IW-1:0] wb0Idx, wb1Idx;
  logic [DW-1:0] wb0Val, wb1Val;
  logic [IW-1:0] queryIdx;
  logic          queryReady;
  logic [DW-1:0] queryVal;
  logic          rfCommitEn;
  logic [IW-1:0] rfCommitIdx;
  logic [RW-1:0] rfCommitDest;
  logic [DW-1:0] rfCommitVal;
  logic          stCommitReq, stCommitAck;
  logic [IW-1:0] stCommitIdx;
  logic          bpUpdateEn, bpTaken, rollBack;
  logic [AW-1:0] bpUpdatePc, corrPc;

  rob_gen2 #(.ROB_DEPTH(DEPTH), .IDX_W(IW), .DATA_W(DW), .ADDR_W(AW), .REG_W(RW)) dut (
    .clk(clk), .rst_in(rstIn), .rdy_in(rdyIn),
    .alloc_en(allocEn), .alloc_op(allocOp), .alloc_ready(allocReady),
    .alloc_dest(allocDest), .alloc_val(allocVal), .alloc_pred_jump(allocPredJump),
    .alloc_pc(allocPc), .alloc_alt_pc(allocAltPc), .alloc_idx(allocIdx),
    .rob_full(robFull), .rob_empty(robEmpty), .rob_count(robCount),
    .wb0_en(wb0En), .wb0_idx(wb0Idx), .wb0_val(wb0Val),
    .wb1_en(wb1En), .wb1_idx(wb1Idx), .wb1_val(wb1Val),
    .query_idx(queryIdx), .query_ready(queryReady), .query_val(queryVal),
    .rf_commit_en(rfCommitEn), .rf_commit_idx(rfCommitIdx),
    .rf_commit_dest(rfCommitDest), .rf_commit_val(rfCommitVal),
    .st_commit_req(stCommitReq), .st_commit_idx(stCommitIdx), .st_commit_ack(stCommitAck),
    .bp_update_en(bpUpdateEn), .bp_update_pc(bpUpdatePc), .bp_taken(bpTaken),
    .roll_back(rollBack), .corr_pc(corrPc)
  );

  int checks = 0;
  int errors = 0;

  // One cycle: inputs applied, and outputs expected during that cycle
  typedef struct {
    logic          rdy;
    logic          allocEn;
    logic [1:0]    allocOp;
    logic          allocReady;
    logic [RW-1:0] allocDest;
    logic [DW-1:0] allocVal;
    logic          predJump;
    logic [AW-1:0] pc;
    logic [AW-1:0] altPc;
    logic          wb0En;
    logic [IW-1:0] wb0Idx;
    logic [DW-1:0] wb0Val;
    logic          wb1En;
    logic [IW-1:0] wb1Idx;
    logic [DW-1:0] wb1Val;
    logic [IW-1:0] queryIdx;
    logic          stAck;
    logic [IW:0]   expCount;
    logic [IW-1:0] expAllocIdx;
    logic          expRfEn;
    logic [IW-1:0] expRfIdx;
    logic [RW-1:0] expRfDest;
    logic [DW-1:0] expRfVal;
    logic          expBpEn;
    logic [AW-1:0] expBpPc;
    logic          expBpTaken;
    logic          expRb;
    logic [AW-1:0] expCorrPc;
    logic          expStReq;
    logic [IW-1:0] expStIdx;
    logic          chkQuery;
    logic          expQReady;
    logic [DW-1:0] expQVal;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [IW:0] cnt, input logic [IW-1:0] aidx);
    vec_t v;
    v.rdy = 1'b1; v.allocEn = 1'b0; v.allocOp = 2'd0; v.allocReady = 1'b0;
    v.allocDest = '0; v.allocVal = '0; v.predJump = 1'b0; v.pc = '0; v.altPc = '0;
    v.wb0En = 1'b0; v.wb0Idx = '0; v.wb0Val = '0;
    v.wb1En = 1'b0; v.wb1Idx = '0; v.wb1Val = '0;
    v.queryIdx = '0; v.stAck = 1'b0;
    v.expCount = cnt; v.expAllocIdx = aidx;
    v.expRfEn = 1'b0; v.expRfIdx = '0; v.expRfDest = '0; v.expRfVal = '0;
    v.expBpEn = 1'b0; v.expBpPc = '0; v.expBpTaken = 1'b0;
    v.expRb = 1'b0; v.expCorrPc = '0;
    v.expStReq = 1'b0; v.expStIdx = '0;
    v.chkQuery = 1'b0; v.expQReady = 1'b0; v.expQVal = '0;
    return v;
  endfunction

  function automatic vec_t withAlloc(input vec_t v, input logic [1:0] op, input logic rdy,
                                     input logic [RW-1:0] dest, input logic [DW-1:0] val,
                                     input logic pred, input logic [AW-1:0] pc,
                                     input logic [AW-1:0] alt);
    v.allocEn = 1'b1; v.allocOp = op; v.allocReady = rdy; v.allocDest = dest;
    v.allocVal = val; v.predJump = pred; v.pc = pc; v.altPc = alt;
    return v;
  endfunction

  function automatic vec_t withWb0(input vec_t v, input logic [IW-1:0] idx, input logic [DW-1:0] val);
    v.wb0En = 1'b1; v.wb0Idx = idx; v.wb0Val = val;
    return v;
  endfunction

  function automatic vec_t withWb1(input vec_t v, input logic [IW-1:0] idx, input logic [DW-1:0] val);
    v.wb1En = 1'b1; v.wb1Idx = idx; v.wb1Val = val;
    return v;
  endfunction

  function automatic vec_t withRf(input vec_t v, input logic [IW-1:0] idx,
                                  input logic [RW-1:0] dest, input logic [DW-1:0] val);
    v.expRfEn = 1'b1; v.expRfIdx = idx; v.expRfDest = dest; v.expRfVal = val;
    return v;
  endfunction

  function automatic vec_t withBp(input vec_t v, input logic [AW-1:0] pc, input logic taken);
    v.expBpEn = 1'b1; v.expBpPc = pc; v.expBpTaken = taken;
    return v;
  endfunction

  function automatic vec_t withRb(input vec_t v, input logic [AW-1:0] pc);
    v.expRb = 1'b1; v.expCorrPc = pc;
    return v;
  endfunction

  function automatic vec_t withQuery(input vec_t v, input logic [IW-1:0] idx,
                                     input logic rdy, input logic [DW-1:0] val);
    v.queryIdx = idx; v.chkQuery = 1'b1; v.expQReady = rdy; v.expQVal = val;
    return v;
  endfunction

  function automatic vec_t withSt(input vec_t v, input logic [IW-1:0] idx);
    v.expStReq = 1'b1; v.expStIdx = idx;
    return v;
  endfunction

  task automatic cmp(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s %s: got 0x%0h, expected 0x%0h", tag, name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rdyIn = v.rdy; allocEn = v.allocEn; allocOp = v.allocOp; allocReady = v.allocReady;
    allocDest = v.allocDest; allocVal = v.allocVal; allocPredJump = v.predJump;
    allocPc = v.pc; allocAltPc = v.altPc;
    wb0En = v.wb0En; wb0Idx = v.wb0Idx; wb0Val = v.wb0Val;
    wb1En = v.wb1En; wb1Idx = v.wb1Idx; wb1Val = v.wb1Val;
    queryIdx = v.queryIdx; stCommitAck = v.stAck;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    cmp(tag, "count", 32'(robCount), 32'(v.expCount));
    cmp(tag, "full", 32'(robFull), 32'(v.expCount == 3'(DEPTH)));
    cmp(tag, "empty", 32'(robEmpty), 32'(v.expCount == 3'd0));
    cmp(tag, "allocIdx", 32'(allocIdx), 32'(v.expAllocIdx));
    cmp(tag, "rfEn", 32'(rfCommitEn), 32'(v.expRfEn));
    cmp(tag, "bpEn", 32'(bpUpdateEn), 32'(v.expBpEn));
    cmp(tag, "rollBack", 32'(rollBack), 32'(v.expRb));
    cmp(tag, "stReq", 32'(stCommitReq), 32'(v.expStReq));
    if (v.expRfEn) begin
      cmp(tag, "rfIdx", 32'(rfCommitIdx), 32'(v.expRfIdx));
      cmp(tag, "rfDest", 32'(rfCommitDest), 32'(v.expRfDest));
      cmp(tag, "rfVal", rfCommitVal, v.expRfVal);
    end
    if (v.expBpEn) begin
      cmp(tag, "bpPc", bpUpdatePc, v.expBpPc);
      cmp(tag, "bpTaken", 32'(bpTaken), 32'(v.expBpTaken));
    end
    if (v.expRb) cmp(tag, "corrPc", corrPc, v.expCorrPc);
    if (v.expStReq) cmp(tag, "stIdx", 32'(stCommitIdx), 32'(v.expStIdx));
    if (v.chkQuery) begin
      cmp(tag, "qReady", 32'(queryReady), 32'(v.expQReady));
      cmp(tag, "qVal", queryVal, v.expQVal);
    end
  endtask

  task automatic runStep(input vec_t v, input string tag);
    @(negedge clk);
    applyStimulus(v);
    #1;
    checkOutput(v, tag);
  endtask

  // Abort guard against a hung run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed test
  initial begin
    vec_t v;
    applyStimulus(mk(0, 0));
    rstIn = 1'b1;
    rdyIn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstIn = 1'b0;
    runStep(withQuery(mk(0, 0), 0, 1'b0, 32'h0), "reset");

    // Fill, full, out-of-order completion, bypass, in-order commits
    tbl.push_back(withAlloc(mk(0, 0), 2'd0, 1'b0, 5'd5, 32'h0, 1'b0, 32'h0, 32'h0));
    tbl.push_back(withAlloc(mk(1, 1), 2'd0, 1'b0, 5'd2, 32'h0, 1'b0, 32'h0, 32'h0));
    tbl.push_back(withAlloc(mk(2, 2), 2'd0, 1'b0, 5'd3, 32'h0, 1'b0, 32'h0, 32'h0));
    tbl.push_back(withAlloc(mk(3, 3), 2'd0, 1'b0, 5'd4, 32'h0, 1'b0, 32'h0, 32'h0));
    tbl.push_back(withAlloc(mk(4, 0), 2'd0, 1'b0, 5'd6, 32'h0, 1'b0, 32'h0, 32'h0));
    tbl.push_back(withQuery(withWb1(mk(4, 0), 1, 32'h22), 1, 1'b1, 32'h22));
    tbl.push_back(withQuery(mk(4, 0), 1, 1'b1, 32'h22));
    tbl.push_back(withQuery(withWb0(mk(4, 0), 0, 32'h1234), 0, 1'b1, 32'h1234));
    tbl.push_back(mk(4, 0));
    tbl.push_back(withRf(mk(3, 0), 0, 5'd5, 32'h1234));
    tbl.push_back(withRf(mk(2, 0), 1, 5'd2, 32'h22));
    tbl.push_back(withQuery(withWb0(mk(2, 0), 2, 32'hAA), 2, 1'b1, 32'hAA));
    tbl.push_back(mk(2, 0));
    tbl.push_back(withQuery(withWb1(withWb0(withRf(mk(1, 0), 2, 5'd3, 32'hAA), 3, 32'h33), 3, 32'h44),
                            3, 1'b1, 32'h44));
    tbl.push_back(mk(1, 0));
    tbl.push_back(withRf(mk(0, 0), 3, 5'd4, 32'h44));
    // Mispredicted branch with a younger entry behind it
    tbl.push_back(withWb1(withAlloc(mk(0, 0), 2'd1, 1'b0, 5'd0, 32'h0, 1'b1, 32'h80, 32'h100), 0, 32'h99));
    tbl.push_back(withAlloc(mk(1, 1), 2'd0, 1'b0, 5'd7, 32'h0, 1'b0, 32'h0, 32'h0));
    tbl.push_back(withWb0(mk(2, 2), 0, 32'h0));
    tbl.push_back(mk(2, 2));
    tbl.push_back(withWb0(withAlloc(withRb(withBp(mk(0, 0), 32'h80, 1'b0), 32'h100),
                                    2'd0, 1'b0, 5'd9, 32'h0, 1'b0, 32'h0, 32'h0), 1, 32'h5));
    // Correctly predicted branch complete at allocation
    tbl.push_back(withAlloc(mk(0, 0), 2'd1, 1'b1, 5'd0, 32'h0, 1'b0, 32'h90, 32'h200));
    tbl.push_back(mk(1, 1));
    tbl.push_back(withBp(mk(0, 1), 32'h90, 1'b0));
    tbl.push_back(mk(0, 1));

    foreach (tbl[i]) runStep(tbl[i], $sformatf("row%0d", i));

    // Store handshake: stray ack, then request held until acknowledged
    v = mk(0, 1); v.stAck = 1'b1;
    runStep(v, "stStrayAck");
    runStep(withAlloc(mk(0, 1), 2'd2, 1'b1, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0), "stAlloc");
    for (int k = 0; k < 3; k++) runStep(withSt(mk(1, 2), 1), $sformatf("stWait%0d", k));
    v = withSt(mk(1, 2), 1); v.stAck = 1'b1;
    runStep(v, "stAck");
    runStep(mk(0, 2), "stDone");

    // Global stall before and after a commit
    runStep(withAlloc(mk(0, 2), 2'd0, 1'b1, 5'd10, 32'h55, 1'b0, 32'h0, 32'h0), "stlAlloc");
    v = mk(1, 3); v.rdy = 1'b0;
    runStep(v, "stl1");
    v = withAlloc(mk(1, 3), 2'd0, 1'b0, 5'd11, 32'h0, 1'b0, 32'h0, 32'h0); v.rdy = 1'b0;
    runStep(v, "stl2");
    runStep(mk(1, 3), "stlRun");
    v = withRf(mk(0, 3), 2, 5'd10, 32'h55); v.rdy = 1'b0;
    runStep(v, "stl3");
    runStep(v, "stl4");
    runStep(withRf(mk(0, 3), 2, 5'd10, 32'h55), "stlResume");
    runStep(mk(0, 3), "stlAfter");

    // Reset with stall asserted while entries are live
    runStep(withAlloc(mk(0, 3), 2'd0, 1'b0, 5'd1, 32'h0, 1'b0, 32'h0, 32'h0), "preRst0");
    runStep(withAlloc(mk(1, 0), 2'd0, 1'b0, 5'd2, 32'h0, 1'b0, 32'h0, 32'h0), "preRst1");
    @(negedge clk);
    applyStimulus(mk(0, 0));
    rstIn = 1'b1;
    rdyIn = 1'b0;
    @(negedge clk);
    rstIn = 1'b0;
    runStep(withQuery(mk(0, 0), 1, 1'b0, 32'h0), "midReset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
